segundos1c: RTL
===============

SEGUNDOS1C -- requirements
Module: segundos1C

Interface
REQ-001 Parameter DEBOUNCE, default 500000, number of clock cycles KEY1 must be stable before a press is accepted.
REQ-002 Parameter MAXDIG, default 5, highest digit value before wrap to 0.
REQ-003 clock  input  1  single system clock; all logic on its rising edge.
REQ-004 KEY0  input  1  reset; synchronous, active-low (0 = reset).
REQ-005 clockIN  input  1  carry from the seconds-units stage; a one-cycle-high pulse per ten seconds.
REQ-006 KEY1  input  1  manual increment pushbutton, active-low (0 = pressed), asynchronous to clock.
REQ-007 SW17  input  1  mode switch: 0 = RUN, 1 = SET.
REQ-008 clockOUT  output  1  carry to the minutes stage; one-cycle-high pulse on wrap.
REQ-009 a, b, c, d, e, f, g  output  1 each  seven-segment drive for the tens-of-seconds digit, active-low (0 = segment lit).

Function
REQ-010 The block SHALL hold a 3-bit digit register in the range 0..MAXDIG.
REQ-011 KEY1 and SW17 SHALL each pass through a 2-flop synchronizer before use. clockIN SHALL be used directly, because it is produced on the same clock.
REQ-012 The block SHALL detect a rising edge of clockIN: clockIN=1 while the previous-cycle registered clockIN=0.
REQ-013 The FSM SHALL have two states, RUN and SET.
  - RUN to SET when synchronized SW17=1.
  - SET to RUN when synchronized SW17=0.
  - The transition takes effect on the cycle after the synchronized value changes.
REQ-014 In RUN, each clockIN rising edge SHALL increment the digit.
  - At MAXDIG the digit wraps to 0.
  - On that same edge clockOUT SHALL be 1 for exactly one cycle; otherwise clockOUT=0.
REQ-015 In RUN, a constant-high clockIN SHALL count only once.
REQ-016 In SET, clockIN SHALL be ignored and clockOUT SHALL stay 0.
REQ-017 Debounce: a counter SHALL count while synchronized KEY1 differs from the stored stable value, and SHALL clear to 0 whenever they match.
  - When the counter reaches DEBOUNCE-1, the stable value SHALL take the new level.
REQ-018 A press is accepted on the stable value going 1 to 0.
  - In SET, an accepted press SHALL increment the digit modulo MAXDIG+1, with no clockOUT pulse.
  - In RUN, accepted presses SHALL be discarded.
REQ-019 A press accepted in the same cycle as an FSM transition SHALL act according to the state before the transition.
REQ-020 Segment outputs SHALL be registered from the digit, so they follow a digit change by one cycle. Encoding, listed as a b c d e f g:
  - 0 = 0000001
  - 1 = 1001111
  - 2 = 0010010
  - 3 = 0000110
  - 4 = 1001100
  - 5 = 0100100
  - any other value = 1111111 (blank)
REQ-021 clockOUT SHALL be registered and asserted in the cycle after the qualifying clockIN edge is sampled.
REQ-022 The counter SHALL never exceed MAXDIG. Any out-of-range value SHALL be forced to 0 on the next clock.

Reset
REQ-023 When KEY0=0 at a rising clock edge, the block SHALL set all of the following; reset has priority over every other event in that cycle:
  - digit = 0
  - FSM = RUN
  - clockOUT = 0
  - a..f = 0 and g = 1
  - edge-detect flop = 0
  - debounce counter = 0
  - stable KEY1 value = 1
  - synchronizers = 1 for KEY1 and 0 for SW17
REQ-024 Reset asserted mid-debounce or mid-pulse SHALL discard the pending press or pulse; no clockOUT SHALL follow release.
REQ-025 After KEY0 returns to 1, the block SHALL operate normally from the next edge.

Verification
REQ-026 Carry count: reset, SW17=0, six one-cycle clockIN pulses 20 cycles apart. Required response:
  - digit 1,2,3,4,5,0
  - a..g ends at 0000001
  - exactly one clockOUT pulse, one cycle wide, on the sixth pulse
REQ-027 Held carry: clockIN held high for 50 cycles from digit 2 -> digit becomes 3 only, no clockOUT.
REQ-028 Set mode, with DEBOUNCE=8: SW17=1, three clean KEY1 presses of 20 cycles low -> digit 3, segments 0000110, clockOUT never 1; a clockIN pulse during SET leaves digit 3.
REQ-029 Bounce, with DEBOUNCE=8: in SET, KEY1 toggling every 3 cycles for 30 cycles then held low 20 cycles -> exactly one increment.
REQ-030 Wrap in SET: digit 5, SW17=1, one press -> digit 0 and no clockOUT.
REQ-031 Reset mid-operation: digit 4 and KEY1 held low for 4 cycles (mid-debounce), then KEY0=0 for one cycle -> next cycle digit 0, FSM RUN, clockOUT 0, segments 0000001; no increment after release.

Source files
------------

// File: rtl/segundos1c_if.sv
// ---------------------------------------------------------------------------
// segundos1c_if -- signal bundle for the tens-of-seconds digit stage.
//   clockIN   : carry pulse in from the seconds-units stage (same clock)
//   KEY1      : manual increment pushbutton, active-low, asynchronous
//   SW17      : mode switch, 0 = RUN, 1 = SET (asynchronous)
//   clockOUT  : carry pulse out to the minutes stage
//   a..g      : seven-segment drive, active-low
// master drives the inputs of the stage, slave is the stage itself.
// ---------------------------------------------------------------------------
interface segundos1c_if;
  logic clockIN;
  logic KEY1;
  logic SW17;
  logic clockOUT;
  logic a, b, c, d, e, f, g;

  modport master (
    output clockIN, KEY1, SW17,
    input  clockOUT, a, b, c, d, e, f, g
  );

  modport slave (
    input  clockIN, KEY1, SW17,
    output clockOUT, a, b, c, d, e, f, g
  );
endinterface

// File: rtl/segundos1c.sv
// ---------------------------------------------------------------------------
// segundos1c -- tens-of-seconds digit of a clock, with manual set mode.
//   clock    : system clock, rising edge
//   KEY0     : synchronous active-low reset
//   bus      : segundos1c_if.slave
//                clockIN  carry in, one-cycle pulse every ten seconds
//                KEY1     pushbutton (active-low), debounced, used in SET
//                SW17     mode: 0 = RUN (count carries), 1 = SET (count presses)
//                clockOUT one-cycle carry pulse when the digit wraps in RUN
//                a..g     active-low segments, one cycle behind the digit
// Parameters:
//   DEBOUNCE : cycles KEY1 must stay at a new level before it is accepted
//   MAXDIG   : highest digit value (at most 7) before wrap to 0
// ---------------------------------------------------------------------------
module segundos1c #(
  parameter int DEBOUNCE = 500000,
  parameter int MAXDIG   = 5
) (
  input  logic         clock,
  input  logic         KEY0,
  segundos1c_if.slave  bus
);

  localparam int             CW      = ($clog2(DEBOUNCE) > 0) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [2:0]     MAXD    = 3'(MAXDIG);

  typedef enum logic {ST_RUN = 1'b0, ST_SET = 1'b1} state_t;

  // Digit increment with wrap; out-of-range values also land on 0.
  function automatic logic [2:0] inc_wrap(input logic [2:0] dig);
    return (dig >= MAXD) ? 3'd0 : dig + 3'd1;
  endfunction

  // Active-low segment pattern {a,b,c,d,e,f,g}; unused codes are blank.
  function automatic logic [6:0] seg_of(input logic [2:0] dig);
    case (dig)
      3'd0:    return 7'b0000001;
      3'd1:    return 7'b1001111;
      3'd2:    return 7'b0010010;
      3'd3:    return 7'b0000110;
      3'd4:    return 7'b1001100;
      3'd5:    return 7'b0100100;
      default: return 7'b1111111;
    endcase
  endfunction

  logic          r_key1_s1, r_key1_s2;
  logic          r_sw_s1, r_sw_s2;
  logic          r_clkin_d;
  logic [CW-1:0] r_db_cnt;
  logic          r_key1_stable;
  state_t        r_state;
  logic [2:0]    r_digit;
  logic          r_clkout;
  logic [6:0]    r_seg;

  logic          w_clkin_rise;
  logic          w_db_differ;
  logic          w_db_take;
  logic          w_press;

  assign w_clkin_rise = bus.clockIN & ~r_clkin_d;
  assign w_db_differ  = (r_key1_s2 != r_key1_stable);
  assign w_db_take    = w_db_differ && (r_db_cnt == DB_LAST);
  // A press is the stable level falling 1 -> 0, seen in the cycle it updates.
  assign w_press      = w_db_take && !r_key1_s2;

  always_ff @(posedge clock) begin
    if (!KEY0) begin
      r_key1_s1     <= 1'b1;
      r_key1_s2     <= 1'b1;
      r_sw_s1       <= 1'b0;
      r_sw_s2       <= 1'b0;
      r_clkin_d     <= 1'b0;
      r_db_cnt      <= '0;
      r_key1_stable <= 1'b1;
      r_state       <= ST_RUN;
      r_digit       <= 3'd0;
      r_clkout      <= 1'b0;
      r_seg         <= 7'b0000001;
    end else begin
      // Stage: synchronizers and carry edge detect
      r_key1_s1 <= bus.KEY1;
      r_key1_s2 <= r_key1_s1;
      r_sw_s1   <= bus.SW17;
      r_sw_s2   <= r_sw_s1;
      r_clkin_d <= bus.clockIN;

      // Stage: debounce of the synchronized pushbutton
      if (!w_db_differ) begin
        r_db_cnt <= '0;
      end else if (w_db_take) begin
        r_db_cnt      <= '0;
        r_key1_stable <= r_key1_s2;
      end else begin
        r_db_cnt <= r_db_cnt + CW'(1);
      end

      // Stage: mode FSM and digit update; the digit decision uses the
      // state before any transition made in this same cycle.
      r_clkout <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (r_sw_s2) r_state <= ST_SET;
          if (r_digit > MAXD) begin
            r_digit <= 3'd0;
          end else if (w_clkin_rise) begin
            r_digit <= inc_wrap(r_digit);
            if (r_digit == MAXD) r_clkout <= 1'b1;
          end
        end
        ST_SET: begin
          if (!r_sw_s2) r_state <= ST_RUN;
          if (r_digit > MAXD) begin
            r_digit <= 3'd0;
          end else if (w_press) begin
            r_digit <= inc_wrap(r_digit);
          end
        end
        default: r_state <= ST_RUN;
      endcase

      // Stage: segment decode, one cycle behind the digit
      r_seg <= seg_of(r_digit);
    end
  end

  assign bus.clockOUT = r_clkout;
  assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = r_seg;

endmodule
